// File: rtl/rfid_spi_xfer_engine.sv
// Wishbone master that sequences single-byte SPI transfers through an SPI master core.
// Initializes SPCR/SPER after reset, then writes SPDR, polls SPSR, reads SPDR and clears flags.
module rfid_spi_xfer_engine #(
  parameter logic [7:0] SPCR_INIT = 8'h50,
  parameter logic [7:0] SPER_INIT = 8'h00,
  parameter int         TMO_W     = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       cyc_o,
  output logic       stb_o,
  output logic [2:0] adr_o,
  output logic       we_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_data_i,
  input  logic [1:0] req_cs_i,
  input  logic       req_last_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic [1:0] spi_cs,
  output logic [3:0] dbg_state_o
);

  // Handshake: a request is taken on the rising edge where req_valid_i && req_ready_o;
  // rsp_valid_o is a one-cycle pulse with no backpressure.
  typedef enum logic [3:0] {
    S_INIT_CR, S_INIT_ER, S_IDLE, S_WR_DR, S_RD_SR,
    S_RD_DR, S_CLR_SR, S_CLR_ERR, S_RESP
  } state_e;

  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

  state_e           state_q, state_d;
  logic             stb_q, stb_d;
  logic [2:0]       adr_q, adr_d;
  logic             we_q, we_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cs_q, cs_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic       bus_req;
  logic       bus_we;
  logic [2:0] bus_adr;
  logic [7:0] bus_dat;
  logic       done;
  logic       timed;

  assign done  = stb_q && ack_i;
  assign timed = (state_q == S_WR_DR) || (state_q == S_RD_SR) ||
                 (state_q == S_RD_DR) || (state_q == S_CLR_SR);

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    adr_d       = adr_q;
    we_d        = we_q;
    dat_d       = dat_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    last_d      = last_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    cs_d        = cs_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_adr     = 3'd0;
    bus_dat     = 8'h00;

    if (timed && tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_INIT_CR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_adr = 3'd0; bus_dat = SPCR_INIT;
        if (done) state_d = S_INIT_ER;
      end
      S_INIT_ER: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_adr = 3'd3; bus_dat = SPER_INIT;
        if (done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid_i) begin
          tx_d    = req_data_i;
          last_d  = req_last_i;
          cs_d    = req_cs_i;
          tmo_d   = '0;
          state_d = S_WR_DR;
        end
      end
      S_WR_DR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_adr = 3'd2; bus_dat = tx_q;
        if (done) state_d = S_RD_SR;
      end
      S_RD_SR: begin
        bus_req = 1'b1; bus_adr = 3'd1;
        // A write collision outranks a completed transfer.
        if (done) begin
          if (dat_i[6])      state_d = S_CLR_ERR;
          else if (dat_i[7]) state_d = S_RD_DR;
        end
      end
      S_RD_DR: begin
        bus_req = 1'b1; bus_adr = 3'd2;
        if (done) begin
          rx_d    = dat_i;
          state_d = S_CLR_SR;
        end
      end
      S_CLR_SR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_adr = 3'd1; bus_dat = 8'hC0;
        if (done) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_CLR_ERR: begin
        bus_req = 1'b1; bus_we = 1'b1; bus_adr = 3'd1; bus_dat = 8'hC0;
        if (done) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_data_d  = err_q ? 8'h00 : rx_q;
        if (last_q || err_q) cs_d = 2'b11;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT_CR;
    endcase

    // Each access raises stb only from an idle bus, which yields the idle cycle after every ack.
    if (bus_req) begin
      if (stb_q) begin
        if (ack_i) stb_d = 1'b0;
      end else begin
        stb_d = 1'b1;
        we_d  = bus_we;
        adr_d = bus_adr;
        dat_d = bus_dat;
      end
    end

    if (timed && tmo_q == TMO_MAX) begin
      stb_d   = 1'b0;
      state_d = S_CLR_ERR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_INIT_CR;
      stb_q       <= 1'b0;
      adr_q       <= 3'd0;
      we_q        <= 1'b0;
      dat_q       <= 8'h00;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      cs_q        <= 2'b11;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      dat_q       <= dat_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cyc_o       = stb_q;
  assign stb_o       = stb_q;
  assign adr_o       = adr_q;
  assign we_o        = we_q;
  assign dat_o       = dat_q;
  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign spi_cs      = cs_q;
  assign dbg_state_o = state_q;

endmodule
